alu_pipe: RTL and testbench
===========================

# alu_pipe

Pipelined, parametrised multi-slice ALU with valid/ready handshakes, unsigned compare flags and a running accumulator. It generalises the single-cycle `WIDTH*n_alu` ALU into a 2-stage, back-pressurable datapath. It sits between the operand sequencer and the result sink, and it is driven by the existing `alu_if`-style BFM with handshake signals added.

## Interface
- `WIDTH`, default 4: bits per ALU slice.
- `N_ALU`, default 4: number of chained slices. Datapath width is `DW = WIDTH*N_ALU`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `arst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `a`  in  DW  operand A, unsigned.
- `b`  in  DW  operand B, unsigned.
- `select`  in  3  opcode of type `alu_op_e`.
- `acc_clr`  in  1  clear the accumulator; qualified by the input handshake.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  sink accepts the result.
- `out`  out  DW  result.
- `carry_out`  out  1  carry, borrow or shifted-out bit.
- `a_greater`, `a_equal`, `a_less`  out  1 each  unsigned compare of the beat's `a` vs `b`; exactly one is high when `out_valid` is high.

## Operation
- Opcodes:
  - 000 ADD: `a+b`; carry = bit `DW`.
  - 001 SUB: `a-b` mod 2^DW; carry = borrow, which is 1 iff `a<b`.
  - 010 AND, 011 OR, 100 XOR: carry = 0.
  - 101 SHL1: `a<<1`; carry = `a[DW-1]`.
  - 110 SHR1: logical `a>>1`; carry = `a[0]`.
  - 111 ACC: `acc = acc + a`; `out` = new `acc`; carry = carry of that add.
- All arithmetic is modulo 2^DW. ADD, SUB and ACC use the ripple chain through `N_ALU` slices, slice 0 being the LSB, with carry-in 0 (SUB uses `~b` with carry-in 1).
- Compare flags are produced for every opcode, ACC included, from that beat's `a` and `b`.
- Accumulator:
  - `DW`-bit register, updated only when an ACC beat moves from stage 1 to stage 2.
  - `acc_clr` travels with its beat. When that beat moves to stage 2, `acc` is zeroed before that beat's own ACC add. A clear with ACC therefore gives `out = a` and `acc = a`. A clear with a non-ACC opcode gives `acc = 0` and leaves the beat's result unaffected.
- Beats leave in acceptance order. No beat is dropped or duplicated except by reset.

## Timing
- Stage 1 (S1) registers `a`, `b`, `select` and `acc_clr` on input handshake (`in_valid && in_ready`).
- Stage 2 (S2) computes and registers all outputs.
- Latency: 2 cycles from input handshake to `out_valid`, when there is no stall. Throughput is 1 beat per cycle.
- `s2_adv = !s2_valid || out_ready`.
- `s1_adv = s1_valid && s2_adv`.
- `in_ready = !arst && (!s1_valid || s2_adv)`. This is combinational from `out_ready`; no skid buffer.
- While `out_valid && !out_ready`, the values of `out`, `carry_out` and the flags are held stable.
- Capacity is 2 beats. `in_ready` falls once S1 and S2 are both full and the sink stalls.
- Reset: in the cycle after `arst` is sampled high:
  - `s1_valid = s2_valid = 0`, so `out_valid = 0`.
  - `out`, `carry_out`, `acc` and all flags are 0.
  - In-flight beats are discarded.
  - `in_ready` is 0 while `arst` is high and 1 in the first cycle after.
- Simultaneous `in_valid` and `out_ready` with both stages full: S2 drains, S1 moves to S2, and the new beat enters S1, all in the same cycle.

## Structure
- Package `alu_pkg` holds:
  - `typedef enum logic [2:0] alu_op_e` with values ADD, SUB, AND, OR, XOR, SHL1, SHR1, ACC;
  - the default parameters `WIDTH` and `N_ALU`;
  - a packed S1 payload struct parameterised through `DW`.
- Sub-module `alu_slice`: one `WIDTH`-bit adder/logic slice with `cin` and `cout`, instantiated `N_ALU` times in a generate ripple chain.
- The top level holds the two pipeline registers, the handshake logic, the accumulator and the shift/compare logic.

## Test plan
All scenarios use `WIDTH=4`, `N_ALU=4`, `DW=16`.
- ADD `a=0xFFFF`, `b=0x0001`, `out_ready=1` → 2 cycles later `out=0x0000`, `carry_out=1`, `a_greater=1`.
- SUB `a=0x0003`, `b=0x0005` → `out=0xFFFE`, `carry_out=1`, `a_less=1`. SUB `a=b=0x1234` → `out=0`, `carry_out=0`, `a_equal=1`.
- SHL1 `a=0x8001` → `out=0x0002`, `carry_out=1`. SHR1 `a=0x8001` → `out=0x4000`, `carry_out=1`.
- ACC with `acc_clr=1` on the first beat, three beats of `a=0x8000` → outputs `0x8000`/c0, then `0x0000`/c1, then `0x8000`/c0.
- Back-pressure: stream 4 ADD beats with `out_ready=0` for 3 cycles → `in_ready` falls after 2 accepted, `out` is held stable, then all 4 results arrive in order once `out_ready=1`.
- Reset mid-flight: 2 beats in the pipe, `arst=1` for 1 cycle → next cycle `out_valid=0`, `acc=0`. A following ACC `a=0x0005` yields `0x0005`.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and defaults for the pipelined multi-slice ALU.
//   alu_op_e   - 3-bit opcode carried with each operand beat
//   s1_ctrl_t  - the control portion of the stage-1 payload (opcode and
//                accumulator clear); the operands are added by alu_pipe
//                so that the full payload follows the DW parameter
//   DEF_WIDTH / DEF_N_ALU - default slice width and slice count
package alu_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_ALU = 4;

  typedef enum logic [2:0] {
    ADD  = 3'b000,
    SUB  = 3'b001,
    AND  = 3'b010,
    OR   = 3'b011,
    XOR  = 3'b100,
    SHL1 = 3'b101,
    SHR1 = 3'b110,
    ACC  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e op;
    logic    acc_clr;
  } s1_ctrl_t;

endpackage

// File: rtl/alu_pipe_slice.sv
// alu_slice: one WIDTH-bit adder/logic slice of the ripple chain.
//   a, b  in  WIDTH  slice operands
//   cin   in  1      carry from the next-lower slice
//   op    in  3      opcode (ADD/SUB/ACC add, AND/OR/XOR logic)
//   y     out WIDTH  slice result (0 for the shift opcodes)
//   cout  out 1      carry into the next-higher slice
module alu_slice
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;

  // SUB is a + ~b + 1; the +1 enters as carry-in of slice 0.
  assign b_eff        = (op == SUB) ? ~b : b;
  assign {cout, sum}  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    unique case (op)
      ADD, SUB, ACC: y = sum;
      AND:           y = a & b;
      OR:            y = a | b;
      XOR:           y = a ^ b;
      default:       y = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready ALU over N_ALU chained WIDTH-bit slices.
//   clk, arst              clock; synchronous active-high reset
//   in_valid/in_ready      operand handshake (a, b, select, acc_clr)
//   out_valid/out_ready    result handshake (out, carry_out, compare flags)
//   a_greater/a_equal/a_less  unsigned compare of the beat's a vs b
// Stage 1 captures the beat; stage 2 computes and registers the result and
// updates the running accumulator.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_ALU = DEF_N_ALU,
  localparam int DW   = WIDTH * N_ALU
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    select,
  input  logic          acc_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out,
  output logic          carry_out,
  output logic          a_greater,
  output logic          a_equal,
  output logic          a_less
);

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    s1_ctrl_t      ctrl;
  } s1_payload_t;

  logic          s1_valid_q, s1_valid_d;
  s1_payload_t   s1_q, s1_d;
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] out_q, out_d;
  logic          carry_q, carry_d;
  logic [2:0]    flags_q, flags_d;   // {greater, equal, less}
  logic [DW-1:0] acc_q, acc_d;

  logic s2_adv, s1_adv, in_fire;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !arst && (!s1_valid_q || s2_adv);
  assign in_fire  = in_valid && in_ready;

  // Ripple chain. ACC reuses it as acc_base + a, so the operands are muxed.
  logic          is_acc;
  logic [DW-1:0] acc_base, chain_x, chain_y, chain_res;
  logic [N_ALU:0] chain_c;
  alu_op_e       slice_op;

  assign is_acc     = (s1_q.ctrl.op == ACC);
  // A clear travelling with the beat zeroes acc before that beat's own add.
  assign acc_base   = s1_q.ctrl.acc_clr ? '0 : acc_q;
  assign chain_x    = is_acc ? acc_base : s1_q.a;
  assign chain_y    = is_acc ? s1_q.a   : s1_q.b;
  assign slice_op   = is_acc ? ADD      : s1_q.ctrl.op;
  assign chain_c[0] = (s1_q.ctrl.op == SUB);

  for (genvar gi = 0; gi < N_ALU; gi++) begin : g_slice
    alu_slice #(.WIDTH(WIDTH)) u_slice (
      .a    (chain_x[gi*WIDTH +: WIDTH]),
      .b    (chain_y[gi*WIDTH +: WIDTH]),
      .cin  (chain_c[gi]),
      .op   (slice_op),
      .y    (chain_res[gi*WIDTH +: WIDTH]),
      .cout (chain_c[gi+1])
    );
  end

  always_comb begin
    // NOTE: every variable gets a hold/default value first so no path
    // through this block leaves it unassigned and infers a latch.
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    carry_d    = carry_q;
    flags_d    = flags_q;
    acc_d      = acc_q;

    if (in_fire) begin
      s1_valid_d       = 1'b1;
      s1_d.a           = a;
      s1_d.b           = b;
      s1_d.ctrl.op     = alu_op_e'(select);
      s1_d.ctrl.acc_clr = acc_clr;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) s2_valid_d = s1_valid_q;

    // Outputs only change when a beat moves into S2, so a stalled
    // result stays stable.
    if (s1_adv) begin
      flags_d = {s1_q.a > s1_q.b, s1_q.a == s1_q.b, s1_q.a < s1_q.b};
      unique case (s1_q.ctrl.op)
        ADD, ACC: begin out_d = chain_res; carry_d = chain_c[N_ALU];  end
        SUB:      begin out_d = chain_res; carry_d = ~chain_c[N_ALU]; end
        SHL1:     begin out_d = {s1_q.a[DW-2:0], 1'b0}; carry_d = s1_q.a[DW-1]; end
        SHR1:     begin out_d = {1'b0, s1_q.a[DW-1:1]}; carry_d = s1_q.a[0]; end
        default:  begin out_d = chain_res; carry_d = 1'b0; end
      endcase
      if (is_acc)                 acc_d = chain_res;
      else if (s1_q.ctrl.acc_clr) acc_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (arst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      flags_q    <= '0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      flags_q    <= flags_d;
      acc_q      <= acc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = out_q;
  assign carry_out = carry_q;
  assign a_greater = flags_q[2];
  assign a_equal   = flags_q[1];
  assign a_less    = flags_q[0];

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=4, N_ALU=4).
// Result vectors are compared as {out[15:0], carry, greater, equal, less}.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        arst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic [2:0]  select;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        carry_out, a_greater, a_equal, a_less;

  int checks   = 0;
  int failures = 0;

  // Stream stimulus/expectations shared by the stream scenarios.
  alu_op_e     s_op  [4];
  logic [15:0] s_a   [4];
  logic [15:0] s_b   [4];
  logic [19:0] s_exp [4];

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(4), .N_ALU(4)) dut (
    .clk(clk), .arst(arst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .carry_out(carry_out),
    .a_greater(a_greater), .a_equal(a_equal), .a_less(a_less)
  );

  function automatic logic [19:0] obs_vec();
    return {out, carry_out, a_greater, a_equal, a_less};
  endfunction

  // Drive one beat with out_ready=1 and wait (bounded) for its result.
  task automatic send_beat(input alu_op_e op, input logic [15:0] av, input logic [15:0] bv,
                           input logic clr, output logic [19:0] obs, output logic ok);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; select = op; a = av; b = bv; acc_clr = clr;
    @(negedge clk);
    in_valid = 1'b0; acc_clr = 1'b0;
    ok  = 1'b0;
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin ok = 1'b1; obs = obs_vec(); break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; select = '0; acc_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++;
    if ({out_valid, obs_vec()} !== 21'd0)
      begin failures++; $display("FAIL reset_outputs got=%h exp=0", {out_valid, obs_vec()}); end
    arst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    logic [19:0] obs; logic ok;
    send_beat(ADD, 16'hFFFF, 16'h0001, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'h0000, 1'b1, 3'b100})
      begin failures++; $display("FAIL add_wrap got=%h ok=%b exp=%h", obs, ok, {16'h0000, 1'b1, 3'b100}); end
  endtask

  task automatic test_sub();
    logic [19:0] obs; logic ok;
    send_beat(SUB, 16'h0003, 16'h0005, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'hFFFE, 1'b1, 3'b001})
      begin failures++; $display("FAIL sub_borrow got=%h ok=%b exp=%h", obs, ok, {16'hFFFE, 1'b1, 3'b001}); end
    send_beat(SUB, 16'h1234, 16'h1234, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'h0000, 1'b0, 3'b010})
      begin failures++; $display("FAIL sub_equal got=%h ok=%b exp=%h", obs, ok, {16'h0000, 1'b0, 3'b010}); end
  endtask

  task automatic test_logic();
    logic [19:0] obs; logic ok;
    send_beat(AND, 16'hF0F0, 16'hFF00, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'hF000, 1'b0, 3'b001})
      begin failures++; $display("FAIL and got=%h ok=%b exp=%h", obs, ok, {16'hF000, 1'b0, 3'b001}); end
    send_beat(OR, 16'hF0F0, 16'hFF00, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'hFFF0, 1'b0, 3'b001})
      begin failures++; $display("FAIL or got=%h ok=%b exp=%h", obs, ok, {16'hFFF0, 1'b0, 3'b001}); end
    send_beat(XOR, 16'hF0F0, 16'hFF00, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'h0FF0, 1'b0, 3'b001})
      begin failures++; $display("FAIL xor got=%h ok=%b exp=%h", obs, ok, {16'h0FF0, 1'b0, 3'b001}); end
  endtask

  task automatic test_shift();
    logic [19:0] obs; logic ok;
    send_beat(SHL1, 16'h8001, 16'h0000, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'h0002, 1'b1, 3'b100})
      begin failures++; $display("FAIL shl1 got=%h ok=%b exp=%h", obs, ok, {16'h0002, 1'b1, 3'b100}); end
    send_beat(SHR1, 16'h8001, 16'h0000, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'h4000, 1'b1, 3'b100})
      begin failures++; $display("FAIL shr1 got=%h ok=%b exp=%h", obs, ok, {16'h4000, 1'b1, 3'b100}); end
  endtask

  task automatic test_acc();
    logic [19:0] obs; logic ok;
    logic [19:0] exp [3];
    exp[0] = {16'h8000, 1'b0, 3'b100};
    exp[1] = {16'h0000, 1'b1, 3'b100};
    exp[2] = {16'h8000, 1'b0, 3'b100};
    for (int i = 0; i < 3; i++) begin
      send_beat(ACC, 16'h8000, 16'h0000, (i == 0), obs, ok);
      checks++;
      if (!ok || obs !== exp[i])
        begin failures++; $display("FAIL acc_beat%0d got=%h ok=%b exp=%h", i, obs, ok, exp[i]); end
    end
  endtask

  // Stream the four s_* beats, holding out_ready low for the first `stall` cycles.
  task automatic run_stream(input int stall, input string tag);
    int sent = 0, got = 0;
    logic held_v = 1'b0, saw_block = 1'b0;
    logic [19:0] held = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= stall);
      acc_clr   = 1'b0;
      if (sent < 4) begin
        in_valid = 1'b1; select = s_op[sent]; a = s_a[sent]; b = s_b[sent];
      end else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        if (held_v) begin
          checks++;
          if (obs_vec() !== held)
            begin failures++; $display("FAIL %s_hold got=%h exp=%h", tag, obs_vec(), held); end
        end
        held = obs_vec(); held_v = 1'b1;
      end else held_v = 1'b0;
      if (in_valid && !in_ready && !saw_block) begin
        saw_block = 1'b1;
        checks++;
        if (sent != 2) begin failures++; $display("FAIL %s_block_point got=%0d exp=2", tag, sent); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (obs_vec() !== s_exp[got])
          begin failures++; $display("FAIL %s_out%0d got=%h exp=%h", tag, got, obs_vec(), s_exp[got]); end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin failures++; $display("FAIL %s_timeout got=%0d exp=4", tag, got); end
    checks++;
    if (saw_block !== (stall > 0))
      begin failures++; $display("FAIL %s_in_ready_drop got=%b exp=%b", tag, saw_block, stall > 0); end
  endtask

  task automatic test_back_to_back();
    s_op[0] = ADD; s_a[0] = 16'h0001; s_b[0] = 16'h0002; s_exp[0] = {16'h0003, 1'b0, 3'b001};
    s_op[1] = ADD; s_a[1] = 16'h1000; s_b[1] = 16'h2000; s_exp[1] = {16'h3000, 1'b0, 3'b001};
    s_op[2] = SUB; s_a[2] = 16'h0010; s_b[2] = 16'h0001; s_exp[2] = {16'h000F, 1'b0, 3'b100};
    s_op[3] = XOR; s_a[3] = 16'hAAAA; s_b[3] = 16'h5555; s_exp[3] = {16'hFFFF, 1'b0, 3'b100};
    run_stream(0, "b2b");
  endtask

  task automatic test_backpressure();
    s_op[0] = ADD; s_a[0] = 16'h0001; s_b[0] = 16'h0001; s_exp[0] = {16'h0002, 1'b0, 3'b010};
    s_op[1] = ADD; s_a[1] = 16'h0002; s_b[1] = 16'h0002; s_exp[1] = {16'h0004, 1'b0, 3'b010};
    s_op[2] = ADD; s_a[2] = 16'h0003; s_b[2] = 16'h0003; s_exp[2] = {16'h0006, 1'b0, 3'b010};
    s_op[3] = ADD; s_a[3] = 16'h7FFF; s_b[3] = 16'h0001; s_exp[3] = {16'h8000, 1'b0, 3'b100};
    run_stream(4, "bp");
  endtask

  task automatic test_reset_midflight();
    logic [19:0] obs; logic ok;
    // Fill both stages with ACC beats under a stalled sink.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; select = ACC; a = 16'h1111; b = 16'h0000; acc_clr = 1'b0;
    @(negedge clk);
    a = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    arst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready got=%b exp=0", in_ready); end
    @(negedge clk);
    arst = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs_vec()} !== 21'd0)
      begin failures++; $display("FAIL midreset_outputs got=%h exp=0", {out_valid, obs_vec()}); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready_after got=%b exp=1", in_ready); end
    send_beat(ACC, 16'h0005, 16'h0000, 1'b0, obs, ok);
    checks++;
    if (!ok || obs !== {16'h0005, 1'b0, 3'b100})
      begin failures++; $display("FAIL midreset_acc got=%h ok=%b exp=%h", obs, ok, {16'h0005, 1'b0, 3'b100}); end
    // Only one result may come out: the discarded beats must not reappear.
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_extra_beat got=%b exp=0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_acc();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
